hamming_receptor: RTL
=====================

HAMMING_RECEPTOR -- requirements
Module: hamming_receptor

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum idle clk cycles between en strobes inside a frame before the frame is aborted.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: frame sync pulse, sampled on the rising edge of clk.
REQ-005 The block SHALL have port en, input, 1 bit: bit strobe; rx_bit is sampled only in cycles where en=1.
REQ-006 The block SHALL have port rx_bit, input, 1 bit: serial Hamming(7,4) codeword bit.
REQ-007 The block SHALL have port data, output, 4 bits: decoded nibble, {b7,b6,b5,b3}, held until the next valid.
REQ-008 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking data, syndrome and err as new.
REQ-009 The block SHALL have port syndrome, output, 3 bits: {c4,c2,c1} of the last frame.
REQ-010 The block SHALL have port err, output, 1 bit: high when the last frame's syndrome is nonzero.
REQ-011 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on frame abort.

Function
REQ-012 The FSM SHALL have states IDLE, RX and DONE.
REQ-013 Codeword bits SHALL arrive in position order b1 first: p1 p2 d1 p4 d2 d3 d4.
REQ-014 In IDLE, start=1 SHALL move to RX with bit count 0 and gap counter 0; an en in that same cycle SHALL NOT be sampled.
REQ-015 In RX, each en=1 cycle SHALL shift rx_bit into position (count+1) and increment count; the 7th sampled bit SHALL move to DONE.
REQ-016 Syndrome SHALL be c1=b1^b3^b5^b7, c2=b2^b3^b6^b7, c4=b4^b5^b6^b7.
REQ-017 On the edge leaving DONE, the block SHALL register data/syndrome/err, drive valid=1 for exactly that following cycle, and return to IDLE (latency: valid is high in the 2nd cycle after the 7th bit is sampled).
REQ-018 Start=1 while in RX SHALL discard the partial frame, pulse frame_err, and restart at count 0.
REQ-019 In RX, if more than TIMEOUT consecutive cycles pass with en=0, the block SHALL pulse frame_err and go to IDLE without valid.
REQ-020 Start and en SHALL be ignored in DONE.
REQ-021 en and rx_bit SHALL be ignored in IDLE.

Reset
REQ-022 While rst_n=0, the FSM SHALL be in IDLE, the counters and shift register SHALL be 0, and data=0, syndrome=0, err=0, valid=0, frame_err=0.
REQ-023 Reset asserted mid-frame SHALL drop the frame with no valid or frame_err pulse after release.

Configuration
REQ-024 With macro HAMMING_CORRECT_EN defined, a nonzero syndrome s SHALL invert bit position s before data is extracted (single-error correction).
REQ-025 Without HAMMING_CORRECT_EN, data SHALL be the uncorrected {b7,b6,b5,b3}; err and syndrome SHALL still be reported (detect-only).

Structure
REQ-026 A shared package hamming_pkg SHALL hold the FSM state encoding, the codeword width (7), the data width (4) and the syndrome function.
REQ-027 The syndrome/correction logic SHALL be one combinational sub-module, hamming_sindrome.
REQ-028 The FSM and counters SHALL live in hamming_receptor.

Verification
REQ-029 Reset, then start, then bits 1010101 on 7 en strobes -> valid pulse with data=1011, syndrome=000, err=0.
REQ-030 Bits 1010001 (b5 flipped) -> syndrome=101, err=1; data=1011 with HAMMING_CORRECT_EN and 1001 without it.
REQ-031 Start, 3 bits, then start again, then 1010101 -> frame_err pulse at the 2nd start, then a single valid with data=1011.
REQ-032 Start, 2 bits, then en=0 for TIMEOUT+1 cycles -> frame_err pulse, FSM in IDLE, no valid.
REQ-033 rst_n=0 after 5 bits, then release -> all outputs 0, no pulses; the next full frame 1010101 decodes to data=1011.
REQ-034 en=1 every 3rd cycle (gaps below TIMEOUT) with 1010101 -> valid in the 2nd cycle after the 7th bit, data=1011.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(7,4) widths, FSM encoding and syndrome function
package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // cw[i-1] holds codeword position b<i>; result is {c4,c2,c1}
  function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic c1, c2, c4;
    c1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    c2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    c4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {c4, c2, c1};
  endfunction

endpackage

// File: rtl/hamming_sindrome.sv
// rtl/hamming_sindrome.sv - combinational syndrome and data extraction; HAMMING_CORRECT_EN enables single-error correction
module hamming_sindrome
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic [SYN_W-1:0]  syndrome_o,
  output logic              err_o
);

  always_comb begin
    syndrome_o = calc_syndrome(cw_i);
    err_o      = |syndrome_o;
`ifdef HAMMING_CORRECT_EN
    // only a syndrome naming a data position (3,5,6,7) can change the nibble
    data_o = {cw_i[6] ^ (syndrome_o == 3'd7),
              cw_i[5] ^ (syndrome_o == 3'd6),
              cw_i[4] ^ (syndrome_o == 3'd5),
              cw_i[2] ^ (syndrome_o == 3'd3)};
`else
    data_o = {cw_i[6], cw_i[5], cw_i[4], cw_i[2]};
`endif
  end

endmodule

// File: rtl/hamming_receptor.sv
// rtl/hamming_receptor.sv - serial Hamming(7,4) frame receiver with timeout and resync
// Correction is enabled by defining HAMMING_CORRECT_EN; default build is detect-only.
module hamming_receptor
  import hamming_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err,
  output logic              frame_err
);

  localparam int GAP_W = $clog2(TIMEOUT + 2);

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic [GAP_W-1:0]    gap_q;
  logic [CW_W-1:0]     sr_q;
  logic [DATA_W-1:0]   data_q;
  logic [SYN_W-1:0]    syn_q;
  logic                err_q;
  logic                valid_q;
  logic                ferr_q;

  logic [DATA_W-1:0]   dec_data;
  logic [SYN_W-1:0]    dec_syn;
  logic                dec_err;

  hamming_sindrome u_sindrome (
    .cw_i       (sr_q),
    .data_o     (dec_data),
    .syndrome_o (dec_syn),
    .err_o      (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RX;
            cnt_q   <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
          end
        end
        ST_RX: begin
          // resync takes priority over a bit strobe in the same cycle
          if (start) begin
            ferr_q <= 1'b1;
            cnt_q  <= '0;
            gap_q  <= '0;
            sr_q   <= '0;
          end else if (en) begin
            sr_q[cnt_q] <= rx_bit;
            cnt_q       <= cnt_q + 3'd1;
            gap_q       <= '0;
            if (cnt_q == 3'd6) state_q <= ST_DONE;
          end else if (gap_q == GAP_W'(TIMEOUT)) begin
            ferr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        ST_DONE: begin
          data_q  <= dec_data;
          syn_q   <= dec_syn;
          err_q   <= dec_err;
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign syndrome  = syn_q;
  assign err       = err_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule
